cpu_core_param: RTL and testbench

Parametrised successor to the 8-bit Mock8080 CPU core: a multi-step fetch/decode/execute engine talking to a synchronous single-port RAM. It generalises data and address width and adds real ALU flags, SUB/logic/INR/DCR, flag-direct conditional jumps, and a downward-growing hardware stack (PUSH/POP/CALL/RET). It sits between the board-level step controller and the RAM block, replacing the 8-bit core.

---
 rtl/cpu_pkg.sv | 64 ++++++
 rtl/cpu_alu.sv | 51 +++++
 rtl/cpu_core_param.sv | 246 ++++++++++++++++++++++++
 tb/tb_cpu_core_param.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the parametrised core: opcodes, state encoding, ALU ops,
// flag positions and the debug bus layout.
package cpu_pkg;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_MVI_B  = 8'h06;
    localparam logic [7:0] OP_MVI_A  = 8'h3E;
    localparam logic [7:0] OP_MOV_BA = 8'h47;
    localparam logic [7:0] OP_MOV_AB = 8'h78;
    localparam logic [7:0] OP_MOV_BC = 8'h41;
    localparam logic [7:0] OP_MOV_CB = 8'h48;
    localparam logic [7:0] OP_MOV_BH = 8'h44;
    localparam logic [7:0] OP_MOV_HB = 8'h60;
    localparam logic [7:0] OP_MOV_BL = 8'h45;
    localparam logic [7:0] OP_MOV_LB = 8'h68;
    localparam logic [7:0] OP_MOV_MB = 8'h70;
    localparam logic [7:0] OP_MOV_BM = 8'h46;
    localparam logic [7:0] OP_ADD_B  = 8'h80;
    localparam logic [7:0] OP_ADD_M  = 8'h86;
    localparam logic [7:0] OP_SUB_B  = 8'h90;
    localparam logic [7:0] OP_ANA_B  = 8'hA0;
    localparam logic [7:0] OP_XRA_B  = 8'hA8;
    localparam logic [7:0] OP_CMP_B  = 8'hB8;
    localparam logic [7:0] OP_INR_A  = 8'h3C;
    localparam logic [7:0] OP_DCR_A  = 8'h3D;
    localparam logic [7:0] OP_JMP    = 8'hC3;
    localparam logic [7:0] OP_JZ     = 8'hCA;
    localparam logic [7:0] OP_JNZ    = 8'hC2;
    localparam logic [7:0] OP_JC     = 8'hDA;
    localparam logic [7:0] OP_JNC    = 8'hD2;
    localparam logic [7:0] OP_CALL   = 8'hCD;
    localparam logic [7:0] OP_RET    = 8'hC9;
    localparam logic [7:0] OP_PUSH_B = 8'hC5;
    localparam logic [7:0] OP_POP_B  = 8'hC1;
    localparam logic [7:0] OP_HLT    = 8'h76;

    typedef enum logic [3:0] {
        F_ADDR = 4'd0,
        F_WAIT = 4'd1,
        F_DEC  = 4'd2,
        EXEC   = 4'd3,
        O_ADDR = 4'd4,
        O_WAIT = 4'd5,
        O_LOAD = 4'd6,
        W_DROP = 4'd7,
        HALT   = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_INC, ALU_DEC
    } alu_op_t;

    // Flags are held as a 4-bit vector so they drop straight into the debug bus.
    localparam int FLAG_CY = 3;
    localparam int FLAG_S  = 2;
    localparam int FLAG_Z  = 1;
    localparam int FLAG_P  = 0;

    // Debug bus, MSB first: {CY,S,Z,P, state, IR, A, B, C, H, L, SP, PC}
    function automatic int dbg_width(input int data_w, input int addr_w);
        return 5 * data_w + 2 * addr_w + 16;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: result plus CY/S/Z/P. INC/DEC pass the incoming carry through.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  alu_op_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cy_in,
    output logic [DATA_W-1:0] result,
    output logic              cy,
    output logic              s,
    output logic              z,
    output logic              p
);

    logic [DATA_W:0] ext;

    always_comb begin
        ext = {1'b0, a};
        cy  = cy_in;
        case (op)
            ALU_ADD: begin
                ext = {1'b0, a} + {1'b0, b};
                cy  = ext[DATA_W];
            end
            // The extra top bit of the difference is the borrow (a < b).
            ALU_SUB: begin
                ext = {1'b0, a} - {1'b0, b};
                cy  = ext[DATA_W];
            end
            ALU_AND: begin
                ext = {1'b0, a & b};
                cy  = 1'b0;
            end
            ALU_XOR: begin
                ext = {1'b0, a ^ b};
                cy  = 1'b0;
            end
            ALU_INC: ext = {1'b0, a + DATA_W'(1)};
            ALU_DEC: ext = {1'b0, a - DATA_W'(1)};
            default: ext = {1'b0, a};
        endcase
        result = ext[DATA_W-1:0];
        s      = result[DATA_W-1];
        z      = (result == '0);
        p      = ~^result;
    end

endmodule

// File: rtl/cpu_core_param.sv
// Stepped fetch/decode/execute core with hardware stack; one FSM state per enabled step.
//
// state  | meaning
// F_ADDR | drive PC onto mem_addr
// F_WAIT | RAM read in flight
// F_DEC  | latch opcode, choose path
// EXEC   | register/ALU op, untaken jump, write setup (MOV M,B / PUSH / CALL push)
// O_ADDR | drive operand/memory/stack address
// O_WAIT | RAM read in flight
// O_LOAD | consume read data
// W_DROP | release mem_we
// HALT   | stopped until reset
module cpu_core_param
    import cpu_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                                 clk_qzt,
    input  logic                                 reset,
    input  logic                                 en,
    input  logic                                 step,
    input  logic [DATA_W-1:0]                    mem_rdata,
    output logic [DATA_W-1:0]                    mem_wdata,
    output logic [ADDR_W-1:0]                    mem_addr,
    output logic                                 mem_we,
    output logic                                 halted,
    output logic [dbg_width(DATA_W, ADDR_W)-1:0] dbg_interface
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, sp, sp_nxt, addr_nxt;
    logic [DATA_W-1:0] reg_a, reg_b, reg_c, reg_h, reg_l, z_tmp;
    logic [DATA_W-1:0] reg_a_nxt, reg_b_nxt, reg_c_nxt, reg_h_nxt, reg_l_nxt, z_tmp_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic [7:0]        ir, ir_nxt, op_d;
    logic [3:0]        flags, flags_nxt;
    logic              we_nxt, jmp_take;

    alu_op_t           alu_op;
    logic [DATA_W-1:0] alu_b, alu_res;
    logic              alu_cy, alu_s, alu_z, alu_p;

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (alu_op),
        .a      (reg_a),
        .b      (alu_b),
        .cy_in  (flags[FLAG_CY]),
        .result (alu_res),
        .cy     (alu_cy),
        .s      (alu_s),
        .z      (alu_z),
        .p      (alu_p)
    );

    always_ff @(posedge clk_qzt or negedge reset) begin
        if (!reset) begin
            state     <= F_ADDR;
            pc        <= RESET_PC;
            sp        <= '1;
            reg_a     <= '0;
            reg_b     <= '0;
            reg_c     <= '0;
            reg_h     <= '0;
            reg_l     <= '0;
            z_tmp     <= '0;
            ir        <= '0;
            flags     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else if (en && step) begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            sp        <= sp_nxt;
            reg_a     <= reg_a_nxt;
            reg_b     <= reg_b_nxt;
            reg_c     <= reg_c_nxt;
            reg_h     <= reg_h_nxt;
            reg_l     <= reg_l_nxt;
            z_tmp     <= z_tmp_nxt;
            ir        <= ir_nxt;
            flags     <= flags_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            mem_we    <= we_nxt;
        end
    end

    // Opcode is decoded straight off the RAM bus in F_DEC, before IR holds it.
    assign op_d  = mem_rdata[7:0];
    assign alu_b = (state == O_LOAD) ? mem_rdata : reg_b;

    always_comb begin
        case (op_d)
            OP_JMP:  jmp_take = 1'b1;
            OP_JZ:   jmp_take = flags[FLAG_Z];
            OP_JNZ:  jmp_take = ~flags[FLAG_Z];
            OP_JC:   jmp_take = flags[FLAG_CY];
            OP_JNC:  jmp_take = ~flags[FLAG_CY];
            default: jmp_take = 1'b0;
        endcase
        case (ir)
            OP_SUB_B, OP_CMP_B: alu_op = ALU_SUB;
            OP_ANA_B:           alu_op = ALU_AND;
            OP_XRA_B:           alu_op = ALU_XOR;
            OP_INR_A:           alu_op = ALU_INC;
            OP_DCR_A:           alu_op = ALU_DEC;
            default:            alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        sp_nxt    = sp;
        reg_a_nxt = reg_a;
        reg_b_nxt = reg_b;
        reg_c_nxt = reg_c;
        reg_h_nxt = reg_h;
        reg_l_nxt = reg_l;
        z_tmp_nxt = z_tmp;
        ir_nxt    = ir;
        flags_nxt = flags;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        we_nxt    = mem_we;
        case (state)
            F_ADDR: begin
                addr_nxt  = pc;
                we_nxt    = 1'b0;
                state_nxt = F_WAIT;
            end
            F_WAIT: state_nxt = F_DEC;
            F_DEC: begin
                ir_nxt = op_d;
                if (op_d == OP_HLT)
                    state_nxt = HALT;
                else if (jmp_take || op_d inside {OP_MVI_B, OP_MVI_A, OP_MOV_BM, OP_ADD_M,
                                                  OP_POP_B, OP_RET, OP_CALL})
                    state_nxt = O_ADDR;
                else
                    state_nxt = EXEC;
            end
            EXEC: begin
                state_nxt = F_ADDR;
                pc_nxt    = pc + ADDR_W'(1);
                case (ir)
                    OP_MOV_BA: reg_b_nxt = reg_a;
                    OP_MOV_AB: reg_a_nxt = reg_b;
                    OP_MOV_BC: reg_b_nxt = reg_c;
                    OP_MOV_CB: reg_c_nxt = reg_b;
                    OP_MOV_BH: reg_b_nxt = reg_h;
                    OP_MOV_HB: reg_h_nxt = reg_b;
                    OP_MOV_BL: reg_b_nxt = reg_l;
                    OP_MOV_LB: reg_l_nxt = reg_b;
                    OP_ADD_B, OP_SUB_B, OP_ANA_B, OP_XRA_B, OP_INR_A, OP_DCR_A: begin
                        reg_a_nxt = alu_res;
                        flags_nxt = {alu_cy, alu_s, alu_z, alu_p};
                    end
                    OP_CMP_B: flags_nxt = {alu_cy, alu_s, alu_z, alu_p};
                    OP_JZ, OP_JNZ, OP_JC, OP_JNC: pc_nxt = pc + ADDR_W'(2);
                    OP_MOV_MB: begin
                        addr_nxt  = reg_h[ADDR_W-1:0];
                        wdata_nxt = reg_b;
                        we_nxt    = 1'b1;
                        state_nxt = W_DROP;
                    end
                    OP_PUSH_B: begin
                        sp_nxt    = sp - ADDR_W'(1);
                        addr_nxt  = sp - ADDR_W'(1);
                        wdata_nxt = reg_b;
                        we_nxt    = 1'b1;
                        state_nxt = W_DROP;
                    end
                    // CALL arrives here after the target fetch; push the return address.
                    OP_CALL: begin
                        sp_nxt    = sp - ADDR_W'(1);
                        addr_nxt  = sp - ADDR_W'(1);
                        wdata_nxt = DATA_W'(pc + ADDR_W'(2));
                        we_nxt    = 1'b1;
                        pc_nxt    = z_tmp[ADDR_W-1:0];
                        state_nxt = W_DROP;
                    end
                    default: ;
                endcase
            end
            O_ADDR: begin
                state_nxt = O_WAIT;
                case (ir)
                    OP_MOV_BM, OP_ADD_M: addr_nxt = reg_h[ADDR_W-1:0];
                    OP_POP_B, OP_RET:    addr_nxt = sp;
                    default:             addr_nxt = pc + ADDR_W'(1);
                endcase
            end
            O_WAIT: state_nxt = O_LOAD;
            O_LOAD: begin
                state_nxt = F_ADDR;
                case (ir)
                    OP_MVI_B: begin
                        reg_b_nxt = mem_rdata;
                        pc_nxt    = pc + ADDR_W'(2);
                    end
                    OP_MVI_A: begin
                        reg_a_nxt = mem_rdata;
                        pc_nxt    = pc + ADDR_W'(2);
                    end
                    OP_MOV_BM: begin
                        reg_b_nxt = mem_rdata;
                        pc_nxt    = pc + ADDR_W'(1);
                    end
                    OP_ADD_M: begin
                        reg_a_nxt = alu_res;
                        flags_nxt = {alu_cy, alu_s, alu_z, alu_p};
                        pc_nxt    = pc + ADDR_W'(1);
                    end
                    OP_POP_B: begin
                        reg_b_nxt = mem_rdata;
                        sp_nxt    = sp + ADDR_W'(1);
                        pc_nxt    = pc + ADDR_W'(1);
                    end
                    OP_RET: begin
                        pc_nxt = mem_rdata[ADDR_W-1:0];
                        sp_nxt = sp + ADDR_W'(1);
                    end
                    OP_CALL: begin
                        z_tmp_nxt = mem_rdata;
                        state_nxt = EXEC;
                    end
                    default: pc_nxt = mem_rdata[ADDR_W-1:0];
                endcase
            end
            W_DROP: begin
                we_nxt    = 1'b0;
                state_nxt = F_ADDR;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = F_ADDR;
        endcase
    end

    assign halted        = (state == HALT);
    assign dbg_interface = {flags, state, ir, reg_a, reg_b, reg_c, reg_h, reg_l, sp, pc};

endmodule

// File: tb/tb_cpu_core_param.sv
// Directed programs on an 8/8 core and a 16/12 core, each with a bench-side synchronous RAM.
module tb_cpu_core_param;

    logic         clk_qzt = 1'b0;
    logic         reset   = 1'b0;
    logic         en      = 1'b1;
    logic         step8   = 1'b0;
    logic         step16  = 1'b0;

    logic [7:0]   rdata8, wdata8, addr8;
    logic         we8, halted8;
    logic [71:0]  dbg8;
    logic [15:0]  rdata16, wdata16;
    logic [11:0]  addr16;
    logic         we16, halted16;
    logic [119:0] dbg16;

    logic [7:0]   mem8 [256];
    logic [15:0]  mem16 [4096];
    logic         clr8 = 1'b0, ld8 = 1'b0, ld16 = 1'b0;
    logic [7:0]   ld_a8, ld_d8;
    logic [11:0]  ld_a16;
    logic [15:0]  ld_d16;

    typedef struct packed {logic [7:0] addr; logic [7:0] data;} wr_t;
    wr_t  wq[$];
    wr_t  wexp;
    logic we_prev = 1'b0;
    int   we_run  = 0;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk_qzt = ~clk_qzt;

    cpu_core_param #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'h00)) dut8 (
        .clk_qzt(clk_qzt), .reset(reset), .en(en), .step(step8),
        .mem_rdata(rdata8), .mem_wdata(wdata8), .mem_addr(addr8), .mem_we(we8),
        .halted(halted8), .dbg_interface(dbg8));

    cpu_core_param #(.DATA_W(16), .ADDR_W(12), .RESET_PC(12'hFFA)) dut16 (
        .clk_qzt(clk_qzt), .reset(reset), .en(en), .step(step16),
        .mem_rdata(rdata16), .mem_wdata(wdata16), .mem_addr(addr16), .mem_we(we16),
        .halted(halted16), .dbg_interface(dbg16));

    always @(posedge clk_qzt) begin
        if (clr8) for (int i = 0; i < 256; i++) mem8[i] <= '0;
        else if (ld8) mem8[ld_a8] <= ld_d8;
        else if (we8) mem8[addr8] <= wdata8;
        rdata8 <= mem8[addr8];
        if (ld16) mem16[ld_a16] <= ld_d16;
        else if (we16) mem16[addr16] <= wdata16;
        rdata16 <= mem16[addr16];
    end

    wire [7:0]  pc8  = dbg8[7:0];
    wire [7:0]  sp8  = dbg8[15:8];
    wire [7:0]  b8   = dbg8[47:40];
    wire [7:0]  a8   = dbg8[55:48];
    wire [3:0]  st8  = dbg8[67:64];
    wire [3:0]  fl8  = dbg8[71:68];
    wire [11:0] pc16 = dbg16[11:0];
    wire [15:0] b16  = dbg16[87:72];
    wire [15:0] a16  = dbg16[103:88];
    wire [3:0]  fl16 = dbg16[119:116];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put8(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk_qzt); ld8 = 1'b1; ld_a8 = a; ld_d8 = d;
        @(negedge clk_qzt); ld8 = 1'b0;
    endtask

    task automatic put16(input logic [11:0] a, input logic [15:0] d);
        @(negedge clk_qzt); ld16 = 1'b1; ld_a16 = a; ld_d16 = d;
        @(negedge clk_qzt); ld16 = 1'b0;
    endtask

    task automatic enter_reset();
        @(negedge clk_qzt); reset = 1'b0; clr8 = 1'b1;
        @(negedge clk_qzt); clr8 = 1'b0;
        we_prev = 1'b0; we_run = 0;
    endtask

    task automatic leave_reset();
        @(negedge clk_qzt); reset = 1'b1;
        @(negedge clk_qzt);
    endtask

    // One enabled step on the 8-bit core, then write-scoreboard bookkeeping.
    task automatic step8_n(input int n);
        repeat (n) begin
            @(negedge clk_qzt); step8 = 1'b1;
            @(negedge clk_qzt); step8 = 1'b0;
            if (we8) begin
                if (!we_prev) begin
                    chk("write_expected", 64'(wq.size() != 0), 64'd1);
                    if (wq.size() != 0) begin
                        wexp = wq.pop_front();
                        chk("write_addr", 64'(addr8), 64'(wexp.addr));
                        chk("write_data", 64'(wdata8), 64'(wexp.data));
                    end
                end
                we_run++;
            end else begin
                if (we_prev) chk("we_one_step", 64'(we_run), 64'd1);
                we_run = 0;
            end
            we_prev = we8;
        end
    endtask

    task automatic step16_n(input int n);
        repeat (n) begin
            @(negedge clk_qzt); step16 = 1'b1;
            @(negedge clk_qzt); step16 = 1'b0;
        end
    endtask

    initial begin
        // 16-bit program straddling the PC wrap: MVI A FFFF; MVI B 0002; ADD B; NOP; HLT at 000
        put16(12'hFFA, 16'h003E); put16(12'hFFB, 16'hFFFF);
        put16(12'hFFC, 16'h0006); put16(12'hFFD, 16'h0002);
        put16(12'hFFE, 16'h0080); put16(12'hFFF, 16'h0000);
        put16(12'h000, 16'h0076);

        // Program 1: MVI B 05; MVI A 03; ADD B; HLT
        enter_reset();
        put8(0, 8'h06); put8(1, 8'h05); put8(2, 8'h3E); put8(3, 8'h03);
        put8(4, 8'h80); put8(5, 8'h76);
        leave_reset();
        chk("rst_pc", 64'(pc8), 64'h00);
        chk("rst_sp", 64'(sp8), 64'hFF);
        chk("rst_state", 64'(st8), 64'd0);
        chk("rst_we_halt", 64'({we8, halted8, addr8, wdata8}), 64'd0);
        chk("rst_pc16", 64'(pc16), 64'hFFA);
        step8_n(6);
        chk("mvi_b_pc", 64'(pc8), 64'h02);
        en = 1'b0;
        repeat (3) begin
            @(negedge clk_qzt); step8 = 1'b1;
            @(negedge clk_qzt); step8 = 1'b0;
        end
        en = 1'b1;
        chk("en_low_hold", 64'({st8, pc8}), 64'h002);
        step8_n(10);
        chk("p1_a", 64'(a8), 64'h08);
        chk("p1_b", 64'(b8), 64'h05);
        chk("p1_flags", 64'(fl8), 64'h0);
        chk("p1_not_halted_16", 64'(halted8), 64'd0);
        step8_n(3);
        chk("p1_halted", 64'(halted8), 64'd1);
        step8_n(2);
        chk("p1_halt_pc", 64'({halted8, st8, pc8}), 64'h1_8_05);

        // Program 2: MVI A FF; MVI B 01; ADD B; INR A; HLT
        enter_reset();
        put8(0, 8'h3E); put8(1, 8'hFF); put8(2, 8'h06); put8(3, 8'h01);
        put8(4, 8'h80); put8(5, 8'h3C); put8(6, 8'h76);
        leave_reset();
        step8_n(16);
        chk("p2_add_a", 64'(a8), 64'h00);
        chk("p2_add_flags", 64'(fl8), 64'b1011);
        step8_n(4);
        chk("p2_inr_a", 64'(a8), 64'h01);
        chk("p2_inr_flags", 64'(fl8), 64'b1000);

        // Program 3: MVI B 05; MVI A 03; CMP B; JC 40 (taken)
        enter_reset();
        put8(0, 8'h06); put8(1, 8'h05); put8(2, 8'h3E); put8(3, 8'h03);
        put8(4, 8'hB8); put8(5, 8'hDA); put8(6, 8'h40); put8(8'h40, 8'h76);
        leave_reset();
        step8_n(16);
        chk("p3_cmp_a", 64'(a8), 64'h03);
        chk("p3_cmp_cy", 64'(fl8[3]), 64'd1);
        step8_n(6);
        chk("p3_jc_taken", 64'(pc8), 64'h40);

        // Same with A=07: no borrow, jump falls through without reading the operand
        enter_reset();
        put8(0, 8'h06); put8(1, 8'h05); put8(2, 8'h3E); put8(3, 8'h07);
        put8(4, 8'hB8); put8(5, 8'hDA); put8(6, 8'h40); put8(7, 8'h76);
        leave_reset();
        step8_n(16);
        chk("p3b_cmp_flags", 64'(fl8), 64'h0);
        for (int i = 0; i < 4; i++) begin
            step8_n(1);
            chk("p3b_no_operand_read", 64'(addr8), 64'h05);
        end
        chk("p3b_pc_plus2", 64'({st8, pc8}), 64'h0_07);
        step8_n(1);
        chk("p3b_next_fetch", 64'(addr8), 64'h07);

        // Program 4: MVI B 5A; CALL 20; HLT  /  20: PUSH B; MOV B,C; POP B; RET
        enter_reset();
        put8(0, 8'h06); put8(1, 8'h5A); put8(2, 8'hCD); put8(3, 8'h20); put8(4, 8'h76);
        put8(8'h20, 8'hC5); put8(8'h21, 8'h41); put8(8'h22, 8'hC1); put8(8'h23, 8'hC9);
        leave_reset();
        step8_n(6);
        wq.push_back('{addr: 8'hFE, data: 8'h04});
        step8_n(8);
        chk("call_pc", 64'(pc8), 64'h20);
        chk("call_sp", 64'(sp8), 64'hFE);
        chk("call_ret_mem", 64'(mem8[8'hFE]), 64'h04);
        wq.push_back('{addr: 8'hFD, data: 8'h5A});
        step8_n(5);
        chk("push_sp", 64'(sp8), 64'hFD);
        step8_n(4);
        chk("mov_bc_b", 64'(b8), 64'h00);
        step8_n(6);
        chk("pop_b", 64'({b8, sp8}), 64'h5A_FE);
        step8_n(6);
        chk("ret_pc_sp", 64'({pc8, sp8}), 64'h04_FF);
        step8_n(3);
        chk("p4_halted", 64'({halted8, pc8}), 64'h1_04);
        chk("p4_writes_done", 64'(wq.size()), 64'd0);

        // Program 5: MVI B 30; MOV H,B; MOV M,B -- reset while mem_we is high
        enter_reset();
        put8(0, 8'h06); put8(1, 8'h30); put8(2, 8'h60); put8(3, 8'h70); put8(4, 8'h76);
        leave_reset();
        wq.push_back('{addr: 8'h30, data: 8'h30});
        step8_n(14);
        chk("movmb_we", 64'(we8), 64'd1);
        repeat (3) @(negedge clk_qzt);
        chk("we_held_no_step", 64'({we8, addr8}), 64'h1_30);
        chk("movmb_pc", 64'(pc8), 64'h04);
        reset = 1'b0;
        #1;
        chk("rst_async_we", 64'({we8, addr8, wdata8}), 64'd0);
        chk("rst_async_pc", 64'(pc8), 64'h00);
        we_prev = 1'b0; we_run = 0;
        leave_reset();
        chk("after_rst_state", 64'({st8, pc8}), 64'h0_00);
        chk("p5_writes_done", 64'(wq.size()), 64'd0);

        // 16/12 core: wide carry and PC wrap FFF -> 000
        step16_n(16);
        chk("w16_a", 64'(a16), 64'h0001);
        chk("w16_b", 64'(b16), 64'h0002);
        chk("w16_flags", 64'(fl16), 64'b1000);
        chk("w16_pc_pre", 64'(pc16), 64'hFFF);
        step16_n(4);
        chk("w16_pc_wrap", 64'(pc16), 64'h000);
        step16_n(3);
        chk("w16_halted", 64'({halted16, pc16}), 64'h1_000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
